// File: rtl/key_schedule.sv
// AES-128 key expansion engine. One round key per clock is derived from the
// previous one and stored in an 11-entry store. A registered read port returns
// any stored key one cycle after it is selected.
module key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_Start,
  input  logic [127:0] i_Key,
  input  logic [3:0]   i_Round_Sel,
  output logic [127:0] o_Round_Key,
  output logic         o_Busy,
  output logic         o_Ready
);

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e       state;
  logic [3:0]   cnt;
  logic [7:0]   rcon;
  logic [127:0] rk [0:10];

  logic [127:0] rk_prev;
  logic [127:0] rk_next;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  t_word;
  logic [31:0]  w0, w1, w2, w3;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // AES S-box: multiplicative inverse (a^254, with 0 -> 0) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // Unregistered expansion step: next round key from rk[cnt-1] and rcon.
  always_comb begin
    rk_prev  = (cnt == 4'd0) ? 128'h0 : rk[cnt - 4'd1];
    rot_word = {rk_prev[23:0], rk_prev[31:24]};
    sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                sbox(rot_word[15:8]), sbox(rot_word[7:0])};
    t_word   = sub_word ^ {rcon, 24'h0};
    w0       = rk_prev[127:96] ^ t_word;
    w1       = rk_prev[95:64] ^ w0;
    w2       = rk_prev[63:32] ^ w1;
    w3       = rk_prev[31:0] ^ w2;
    rk_next  = {w0, w1, w2, w3};
  end

  // FSM, round counter, rcon, key store and registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      cnt         <= 4'd0;
      rcon        <= 8'h01;
      o_Round_Key <= 128'h0;
      for (int i = 0; i <= 10; i++) rk[i] <= 128'h0;
    end else begin
      // Read sees the store before this edge's write (no write-through).
      o_Round_Key <= (i_Round_Sel <= 4'd10) ? rk[i_Round_Sel] : 128'h0;
      unique case (state)
        StIdle, StDone: begin
          if (i_Start) begin
            rk[0] <= i_Key;
            cnt   <= 4'd1;
            rcon  <= 8'h01;
            state <= StExpand;
          end
        end
        StExpand: begin
          rk[cnt] <= rk_next;
          cnt     <= cnt + 4'd1;
          rcon    <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (cnt == 4'd10) state <= StDone;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Status flags decode directly from the state register.
  always_comb begin
    o_Busy  = (state == StExpand);
    o_Ready = (state == StDone);
  end

endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule: reference model built from the
// FIPS-197 word-recurrence form of the key schedule, checked every cycle,
// plus directed scenarios with literal expectations.
module tb_key_schedule;

  logic         clk;
  logic         rst;
  logic         i_Start;
  logic [127:0] i_Key;
  logic [3:0]   i_Round_Sel;
  logic [127:0] o_Round_Key;
  logic         o_Busy;
  logic         o_Ready;

  key_schedule dut (
    .clk         (clk),
    .rst         (rst),
    .i_Start     (i_Start),
    .i_Key       (i_Key),
    .i_Round_Sel (i_Round_Sel),
    .o_Round_Key (o_Round_Key),
    .o_Busy      (o_Busy),
    .o_Ready     (o_Ready)
  );

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsRk1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FipsRk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZeroRk1 = 128'h62636363626363636263636362636363;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit [7:0] sbox_t [256];

  // Carry-less product followed by reduction by 0x11b.
  function automatic bit [7:0] ref_mul(input bit [7:0] a, input bit [7:0] b);
    bit [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    bit [7:0] inv;
    bit [7:0] s;
    bit [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
               ^ inv[(i + 7) % 8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  // Round key r of the AES-128 schedule via w[i] = w[i-4] ^ temp.
  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    bit [31:0] w [44];
    bit [31:0] tmp;
    bit [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc = ref_mul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endfunction

  logic [127:0] m_rk [0:10];
  logic [127:0] m_key;
  int           m_step;
  bit           m_busy;
  bit           m_ready;
  logic [127:0] m_out;

  // Cycle-level view: one stored key per edge, reads see pre-edge contents.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= 10; i++) m_rk[i] <= '0;
      m_busy  <= 1'b0;
      m_ready <= 1'b0;
      m_out   <= '0;
      m_step  <= 0;
      m_key   <= '0;
    end else begin
      m_out <= (i_Round_Sel <= 4'd10) ? m_rk[i_Round_Sel] : '0;
      if (m_busy) begin
        m_rk[m_step] <= round_key(m_key, m_step);
        m_step <= m_step + 1;
        if (m_step == 10) begin
          m_busy  <= 1'b0;
          m_ready <= 1'b1;
        end
      end else if (i_Start) begin
        m_key   <= i_Key;
        m_rk[0] <= i_Key;
        m_step  <= 1;
        m_busy  <= 1'b1;
        m_ready <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model busy", 128'(o_Busy), 128'(m_busy));
      check("model ready", 128'(o_Ready), 128'(m_ready));
      check("model round_key", o_Round_Key, m_out);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Pulse start, then count edges (including the start edge) until ready.
  task automatic run_start(input logic [127:0] key, output int edges, output int busy_cyc);
    i_Key   = key;
    i_Start = 1'b1;
    step();
    i_Start = 1'b0;
    edges = 1;
    busy_cyc = o_Busy ? 1 : 0;
    while (!o_Ready && edges < 30) begin
      step();
      edges++;
      if (o_Busy) busy_cyc++;
    end
  endtask

  task automatic read_key(input logic [3:0] sel, output logic [127:0] val);
    i_Round_Sel = sel;
    step();
    val = o_Round_Key;
  endtask

  logic [127:0] rd;
  int edges;
  int busy_cyc;

  initial begin
    rst = 1'b1;
    i_Start = 1'b0;
    i_Key = '0;
    i_Round_Sel = 4'd0;
    build_sbox();

    // Pin the model against published values.
    check("model fips rk1", round_key(FipsKey, 1), FipsRk1);
    check("model fips rk10", round_key(FipsKey, 10), FipsRk10);
    check("model zero rk1", round_key('0, 1), ZeroRk1);

    repeat (2) @(posedge clk);
    #2;
    check("reset round_key", o_Round_Key, '0);
    check("reset busy", 128'(o_Busy), 128'(0));
    check("reset ready", 128'(o_Ready), 128'(0));
    rst = 1'b0;
    chk_en = 1'b1;

    // FIPS-197 key, start on the first edge after reset release.
    run_start(FipsKey, edges, busy_cyc);
    check("fips latency", 128'(edges), 128'(11));
    read_key(4'd1, rd);
    check("fips sel1", rd, FipsRk1);
    read_key(4'd10, rd);
    check("fips sel10", rd, FipsRk10);
    read_key(4'd0, rd);
    check("fips sel0", rd, FipsKey);

    // Zero key: busy for exactly 10 sampled cycles.
    run_start('0, edges, busy_cyc);
    check("zero busy cycles", 128'(busy_cyc), 128'(10));
    read_key(4'd1, rd);
    check("zero sel1", rd, ZeroRk1);

    // Start during expansion is ignored and the key is not re-sampled.
    i_Key = FipsKey;
    i_Start = 1'b1;
    step();
    i_Start = 1'b0;
    repeat (3) step();
    i_Key = '0;
    i_Start = 1'b1;
    step();
    i_Start = 1'b0;
    edges = 5;
    while (!o_Ready && edges < 30) begin
      step();
      edges++;
    end
    check("ignored start latency", 128'(edges), 128'(11));
    read_key(4'd10, rd);
    check("ignored start sel10", rd, FipsRk10);

    // Asynchronous reset mid-expansion.
    i_Round_Sel = 4'd0;
    i_Key = FipsKey;
    i_Start = 1'b1;
    step();
    i_Start = 1'b0;
    repeat (4) step();
    check("pre-reset round_key", o_Round_Key, FipsKey);
    #1 rst = 1'b1;
    #1;
    check("async reset round_key", o_Round_Key, '0);
    check("async reset busy", 128'(o_Busy), 128'(0));
    check("async reset ready", 128'(o_Ready), 128'(0));
    step();
    rst = 1'b0;
    i_Round_Sel = 4'd1;
    repeat (13) step();
    check("post-reset sel1", o_Round_Key, '0);
    check("post-reset ready", 128'(o_Ready), 128'(0));

    // Out-of-range reads and restart from DONE.
    run_start(FipsKey, edges, busy_cyc);
    read_key(4'd11, rd);
    check("sel11 zero", rd, '0);
    read_key(4'd15, rd);
    check("sel15 zero", rd, '0);
    i_Key = '0;
    i_Start = 1'b1;
    step();
    i_Start = 1'b0;
    check("restart ready drop", 128'(o_Ready), 128'(0));
    edges = 1;
    while (!o_Ready && edges < 30) begin
      step();
      edges++;
    end
    check("restart latency", 128'(edges), 128'(11));
    read_key(4'd1, rd);
    check("restart sel1", rd, ZeroRk1);

    // Start held high: restarts only on edges taken in DONE.
    i_Key = FipsKey;
    i_Start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      i_Round_Sel = 4'($urandom_range(0, 15));
      step();
    end
    i_Start = 1'b0;

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      i_Start = ($urandom_range(0, 15) == 0);
      i_Key = {$urandom, $urandom, $urandom, $urandom};
      i_Round_Sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
